// File: rtl/player_move_arbiter.sv
// -----------------------------------------------------------------------------
// player_move_arbiter
//
// Chooses who drives the player ship: the keyboard (manual mode) or a simple
// autopilot (demo / attract mode). The autopilot takes over after a run of
// frames with no key held. It sweeps the ship right and left between two X
// limits and fires at a fixed frame interval. Any key press hands control
// straight back to the player. All frame-timed decisions are taken on
// startOfFrame.
//
// Parameters
//   IDLE_FRAMES       consecutive idle frames before demo starts
//   DEMO_RIGHT_LIMIT  shipX at/above which the demo turns left
//   DEMO_LEFT_LIMIT   shipX at/below which the demo turns right
//   DEMO_FIRE_PERIOD  frames between autopilot fire requests
//
// Ports
//   clk           in   system clock
//   resetN        in   asynchronous, active-low reset
//   startOfFrame  in   one-clk pulse per frame
//   keyRight      in   right key held (level)
//   keyLeft       in   left key held (level)
//   keyFire       in   fire key held (level)
//   shipX         in   signed [10:0] current ship top-left X, in pixels
//   RightMove     out  registered move-right command
//   LeftMove      out  registered move-left command
//   fireReq       out  registered one-clk fire pulse
//   demoActive    out  registered, high while the autopilot is in control
// -----------------------------------------------------------------------------
module player_move_arbiter #(
  parameter int IDLE_FRAMES      = 300,
  parameter int DEMO_RIGHT_LIMIT = 570,
  parameter int DEMO_LEFT_LIMIT  = 5,
  parameter int DEMO_FIRE_PERIOD = 45
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               keyRight,
  input  logic               keyLeft,
  input  logic               keyFire,
  input  logic signed [10:0] shipX,
  output logic               RightMove,
  output logic               LeftMove,
  output logic               fireReq,
  output logic               demoActive
);

  // Counter widths. The idle counter must be able to hold IDLE_FRAMES
  // itself. The fire counter only has to reach DEMO_FIRE_PERIOD-1.
  localparam int IDLE_W = (IDLE_FRAMES > 0) ? $clog2(IDLE_FRAMES + 1) : 1;
  localparam int FIRE_W = (DEMO_FIRE_PERIOD > 1) ? $clog2(DEMO_FIRE_PERIOD) : 1;

  localparam logic [IDLE_W-1:0]  IDLE_MAX  = IDLE_W'(IDLE_FRAMES);
  localparam logic [FIRE_W-1:0]  FIRE_LAST = FIRE_W'(DEMO_FIRE_PERIOD - 1);
  localparam logic signed [10:0] RIGHT_LIM = 11'(DEMO_RIGHT_LIMIT);
  localparam logic signed [10:0] LEFT_LIM  = 11'(DEMO_LEFT_LIMIT);

  typedef enum logic [1:0] {
    ST_MANUAL     = 2'd0,
    ST_DEMO_RIGHT = 2'd1,
    ST_DEMO_LEFT  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t              r_state;
  logic [IDLE_W-1:0]   r_idle_cnt;
  logic [FIRE_W-1:0]   r_fire_cnt;
  logic                r_key_fire_d;
  logic                r_right_move;
  logic                r_left_move;
  logic                r_fire_req;
  logic                r_demo_active;

  // Next-state values produced by the combinational block
  state_t              w_next_state;
  logic [IDLE_W-1:0]   w_idle_cnt_nxt;
  logic [FIRE_W-1:0]   w_fire_cnt_nxt;
  logic                w_any_key;
  logic                w_fire_edge;
  logic                w_fire_nxt;
  logic                w_right_nxt;
  logic                w_left_nxt;
  logic                w_demo_nxt;

  assign w_any_key   = keyRight | keyLeft | keyFire;
  assign w_fire_edge = keyFire & ~r_key_fire_d;

  // ---------------------------------------------------------------------------
  // Next-state, counters and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_next_state   = r_state;
    w_idle_cnt_nxt = r_idle_cnt;
    w_fire_cnt_nxt = r_fire_cnt;
    w_fire_nxt     = 1'b0;

    unique case (r_state)
      ST_MANUAL: begin
        if (w_any_key) begin
          w_idle_cnt_nxt = '0;
          w_fire_nxt     = w_fire_edge;
        end else if (startOfFrame) begin
          // The count saturates at IDLE_MAX. The frame that finds it already
          // saturated is the one that hands over to the autopilot.
          if (r_idle_cnt == IDLE_MAX) begin
            w_next_state   = ST_DEMO_RIGHT;
            w_fire_cnt_nxt = '0;
          end else begin
            w_idle_cnt_nxt = r_idle_cnt + 1'b1;
          end
        end
      end

      ST_DEMO_RIGHT, ST_DEMO_LEFT: begin
        if (w_any_key) begin
          // A key press takes priority over any frame decision in this cycle.
          // The key is consumed, so even a fresh keyFire edge does not fire.
          w_next_state   = ST_MANUAL;
          w_idle_cnt_nxt = '0;
        end else if (startOfFrame) begin
          if (r_fire_cnt == FIRE_LAST) begin
            w_fire_nxt     = 1'b1;
            w_fire_cnt_nxt = '0;
          end else begin
            w_fire_cnt_nxt = r_fire_cnt + 1'b1;
          end

          if (r_state == ST_DEMO_RIGHT && shipX >= RIGHT_LIM)
            w_next_state = ST_DEMO_LEFT;
          else if (r_state == ST_DEMO_LEFT && shipX <= LEFT_LIM)
            w_next_state = ST_DEMO_RIGHT;
        end
      end

      default: w_next_state = ST_MANUAL;
    endcase
  end

  // Movement outputs follow the state being entered. That way a demo
  // direction change shows on the outputs one clk after its startOfFrame,
  // together with demoActive.
  always_comb begin
    w_right_nxt = 1'b0;
    w_left_nxt  = 1'b0;
    w_demo_nxt  = 1'b0;
    unique case (w_next_state)
      ST_MANUAL: begin
        w_right_nxt = keyRight & ~keyLeft;
        w_left_nxt  = keyLeft & ~keyRight;
      end
      ST_DEMO_RIGHT: begin
        w_right_nxt = 1'b1;
        w_demo_nxt  = 1'b1;
      end
      ST_DEMO_LEFT: begin
        w_left_nxt  = 1'b1;
        w_demo_nxt  = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state       <= ST_MANUAL;
      r_idle_cnt    <= '0;
      r_fire_cnt    <= '0;
      r_key_fire_d  <= 1'b0;
      r_right_move  <= 1'b0;
      r_left_move   <= 1'b0;
      r_fire_req    <= 1'b0;
      r_demo_active <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register here samples the
      // values from before this edge, whatever order the lines are in.
      r_state       <= w_next_state;
      r_idle_cnt    <= w_idle_cnt_nxt;
      r_fire_cnt    <= w_fire_cnt_nxt;
      // Keep tracking keyFire in demo too. A key held across the exit
      // from demo then does not look like a new press.
      r_key_fire_d  <= keyFire;
      r_right_move  <= w_right_nxt;
      r_left_move   <= w_left_nxt;
      r_fire_req    <= w_fire_nxt;
      r_demo_active <= w_demo_nxt;
    end
  end

  assign RightMove  = r_right_move;
  assign LeftMove   = r_left_move;
  assign fireReq    = r_fire_req;
  assign demoActive = r_demo_active;

  // A manual edge needs keyFire low the clk before, and a demo pulse needs a
  // startOfFrame. So two back-to-back pulses would mean a logic error.
  a_fire_single : assert property (@(posedge clk) disable iff (!resetN)
    r_fire_req |=> !r_fire_req);

endmodule

// File: tb/tb_player_move_arbiter.sv
// -----------------------------------------------------------------------------
// tb_player_move_arbiter
//
// Bench for player_move_arbiter with default parameters. A reference model
// runs at every clock edge. It works from the arbitration rules: a frame
// count since the last key press, a frame count since demo entry, and a
// sweep direction. It pushes the expected outputs into a queue, and a
// monitor on the falling edge pops them and compares. Directed phases follow
// the test plan on top of randomized manual traffic and random shipX.
// -----------------------------------------------------------------------------
module tb_player_move_arbiter;

  localparam int IDLE_FRAMES = 300;
  localparam int RIGHT_LIM   = 570;
  localparam int LEFT_LIM    = 5;
  localparam int FIRE_PERIOD = 45;
  localparam int FRAME_CLKS  = 4;

  logic               clk = 1'b0;
  logic               resetN = 1'b0;
  logic               startOfFrame = 1'b0;
  logic               keyRight = 1'b0;
  logic               keyLeft = 1'b0;
  logic               keyFire = 1'b0;
  logic signed [10:0] shipX = 11'sd300;
  logic               RightMove, LeftMove, fireReq, demoActive;

  int n_tests = 0;
  int n_fail  = 0;
  int n_fire_seen = 0;

  player_move_arbiter dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .keyRight     (keyRight),
    .keyLeft      (keyLeft),
    .keyFire      (keyFire),
    .shipX        (shipX),
    .RightMove    (RightMove),
    .LeftMove     (LeftMove),
    .fireReq      (fireReq),
    .demoActive   (demoActive)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: {RightMove, LeftMove, fireReq, demoActive} expected after
  // each rising edge
  // ---------------------------------------------------------------------------
  logic [3:0] exp_q[$];
  bit m_demo        = 0;
  bit m_going_right = 0;
  int m_idle_frames = 0;
  int m_demo_frames = 0;
  bit m_prev_fire   = 0;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_demo        = 0;
      m_going_right = 0;
      m_idle_frames = 0;
      m_demo_frames = 0;
      m_prev_fire   = 0;
      exp_q.delete();
    end else begin
      bit any_key, fire, r, l;
      any_key = keyRight || keyLeft || keyFire;
      fire = 0;
      if (m_demo) begin
        if (any_key) begin
          m_demo        = 0;
          m_idle_frames = 0;
        end else if (startOfFrame) begin
          m_demo_frames++;
          fire = (m_demo_frames % FIRE_PERIOD) == 0;
          if (m_going_right && int'(shipX) >= RIGHT_LIM)
            m_going_right = 0;
          else if (!m_going_right && int'(shipX) <= LEFT_LIM)
            m_going_right = 1;
        end
      end else begin
        if (any_key) begin
          m_idle_frames = 0;
          fire = keyFire && !m_prev_fire;
        end else if (startOfFrame) begin
          if (m_idle_frames >= IDLE_FRAMES) begin
            m_demo        = 1;
            m_going_right = 1;
            m_demo_frames = 0;
          end else begin
            m_idle_frames++;
          end
        end
      end
      m_prev_fire = keyFire;
      r = m_demo ? m_going_right  : (keyRight && !keyLeft);
      l = m_demo ? !m_going_right : (keyLeft && !keyRight);
      exp_q.push_back({r, l, fire, m_demo});
    end
  end

  // Monitor: the outputs are registered, so one expectation per clock
  always @(negedge clk) begin
    if (resetN && exp_q.size() > 0) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      check("scoreboard", {RightMove, LeftMove, fireReq, demoActive}, e);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Drives one clk of inputs. Returns just after the edge that samples them.
  task automatic cyc(input bit sof, input bit kr, input bit kl, input bit kf,
                     input logic signed [10:0] x);
    @(negedge clk);
    startOfFrame = sof;
    keyRight     = kr;
    keyLeft      = kl;
    keyFire      = kf;
    shipX        = x;
    @(posedge clk);
    #1;
    if (fireReq) n_fire_seen++;
  endtask

  // One frame: keys only during the startOfFrame clk, then idle clks.
  task automatic frame(input bit kr, input bit kl, input bit kf,
                       input logic signed [10:0] x);
    cyc(1'b1, kr, kl, kf, x);
    for (int i = 1; i < FRAME_CLKS; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, x);
  endtask

  // Expects no keys since the last clear: demo must not start on pulse
  // IDLE_FRAMES, and must start on pulse IDLE_FRAMES+1.
  task automatic idle_to_demo(input string tag);
    for (int f = 1; f <= IDLE_FRAMES; f++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 11'sd300);
      if (f == IDLE_FRAMES) check({tag, "_not_yet"}, {3'b000, demoActive}, 4'b0000);
      for (int i = 1; i < FRAME_CLKS; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 11'sd300);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 11'sd300);
    check({tag, "_entry"}, {RightMove, LeftMove, 1'b0, demoActive}, 4'b1001);
    for (int i = 1; i < FRAME_CLKS; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 11'sd300);
  endtask

  function automatic logic signed [10:0] rand_x(input int lo, input int hi);
    int v;
    v = lo + int'($urandom_range(0, hi - lo));
    return 11'(v);
  endfunction

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int fires_before;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {RightMove, LeftMove, fireReq, demoActive}, 4'b0000);
    @(negedge clk);
    resetN = 1'b1;

    // Manual keys
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 11'sd300);
    check("manual_right", {RightMove, LeftMove, fireReq, demoActive}, 4'b1000);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 11'sd300);
    check("manual_both", {RightMove, LeftMove, fireReq, demoActive}, 4'b0000);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 11'sd300);
    check("manual_left", {RightMove, LeftMove, fireReq, demoActive}, 4'b0100);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 11'sd300);

    // Idle timeout, with a key press on pulse 150 that restarts the count
    for (int f = 1; f <= 150; f++) frame(1'b0, (f == 150), 1'b0, 11'sd300);
    check("no_demo_after_150", {3'b000, demoActive}, 4'b0000);
    idle_to_demo("idle1");

    // Demo sweep, reversal points and periodic fire. Frame count since entry
    // is f, so autopilot fire is expected on frames 45 and 90.
    fires_before = n_fire_seen;
    for (int f = 1; f <= 90; f++) begin
      logic signed [10:0] x;
      if (f == 11)      x = 11'sd569;
      else if (f == 12) x = 11'sd570;
      else if (f == 21) x = 11'sd5;
      else if (f > 21)  x = rand_x(6, 569);
      else              x = 11'sd300;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, x);
      if (f == 11) check("demo_569_still_right", {RightMove, LeftMove, 2'b00}, 4'b1000);
      if (f == 12) check("demo_570_turns_left", {RightMove, LeftMove, 2'b00}, 4'b0100);
      if (f == 21) check("demo_5_turns_right", {RightMove, LeftMove, 2'b00}, 4'b1000);
      if (f == 45 || f == 90) check("demo_fire_pulse", {3'b000, fireReq}, 4'b0001);
      for (int i = 1; i < FRAME_CLKS; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, x);
    end
    check("demo_fire_count_90", 4'(n_fire_seen - fires_before), 4'd2);

    // Random shipX while still in demo
    for (int f = 0; f < 30; f++) frame(1'b0, 1'b0, 1'b0, rand_x(-50, 700));

    // Exit on keyFire in the same clk as startOfFrame: the press is consumed
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 11'sd300);
    check("exit_on_fire", {RightMove, LeftMove, fireReq, demoActive}, 4'b0000);
    for (int i = 0; i < 5; i++) cyc((i == 2), 1'b0, 1'b0, 1'b1, 11'sd300);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 11'sd300);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 11'sd300);

    // Manual fire: hold for 10 clks, exactly one pulse one clk after the edge
    fires_before = n_fire_seen;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 11'sd300);
      if (i == 0) check("manual_fire_latency", {3'b000, fireReq}, 4'b0001);
    end
    check("manual_fire_once", 4'(n_fire_seen - fires_before), 4'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 11'sd300);

    // Randomized manual traffic
    for (int i = 0; i < 400; i++)
      cyc((i % FRAME_CLKS) == 0, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
          $urandom_range(0, 99) < 25, rand_x(-50, 700));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 11'sd300);

    // Second demo entry, turn left, then reset mid-demo
    idle_to_demo("idle2");
    frame(1'b0, 1'b0, 1'b0, 11'sd600);
    check("demo_left_before_reset", {RightMove, LeftMove, 1'b0, demoActive}, 4'b0101);
    frame(1'b0, 1'b0, 1'b0, 11'sd300);
    @(posedge clk);
    #2;
    resetN = 1'b0;
    #1;
    check("async_reset_mid_demo", {RightMove, LeftMove, fireReq, demoActive}, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;

    // The idle count starts again from zero after reset
    idle_to_demo("idle3");
    frame(1'b0, 1'b0, 1'b0, 11'sd300);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 11'sd300);
    check("exit_to_manual_right", {RightMove, LeftMove, fireReq, demoActive}, 4'b1000);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 11'sd300);

    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/player_move_arbiter.md
# player_move_arbiter

Arbitrates the movement and fire commands driving the player ship. Selects between keyboard input (manual mode) and a built-in autopilot (demo/attract mode) that takes over after a period of no input. Sits between the keyboard decoder and the ship move/collision datapath, driving its RightMove/LeftMove inputs, and issues fire requests to the missile logic. All decisions that depend on frame timing are taken on startOfFrame.

## Interface
Parameters:
- IDLE_FRAMES, default 300: consecutive idle frames (about 10 s at 30 Hz) before entering demo.
- DEMO_RIGHT_LIMIT, default 570: shipX at or above which demo reverses to the left.
- DEMO_LEFT_LIMIT, default 5: shipX at or below which demo reverses to the right.
- DEMO_FIRE_PERIOD, default 45: frames between autopilot fire requests.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-clk pulse per frame.
- keyRight  in  1  level; right key held.
- keyLeft  in  1  level; left key held.
- keyFire  in  1  level; fire key held.
- shipX  in  11 signed  current ship top-left X, in pixels.
- RightMove  out  1  registered; move-right command.
- LeftMove  out  1  registered; move-left command.
- fireReq  out  1  registered; one-clk fire pulse.
- demoActive  out  1  registered; high while in a DEMO state.

## Operation
- States: MANUAL (reset state), DEMO_RIGHT, DEMO_LEFT.
- anyKey = keyRight | keyLeft | keyFire.
- MANUAL:
  - RightMove = keyRight & ~keyLeft.
  - LeftMove = keyLeft & ~keyRight.
  - If both keys are held, both outputs are 0.
  - fireReq pulses on each keyFire rising edge. The edge detector uses a registered copy of keyFire, which is always updated, including during demo.
- Idle counter:
  - Cleared on any clk where anyKey = 1.
  - Incremented on startOfFrame while anyKey = 0.
  - Saturates at IDLE_FRAMES. Width is $clog2(IDLE_FRAMES+1).
  - On a startOfFrame where the count has already reached IDLE_FRAMES, go to DEMO_RIGHT and clear the fire counter.
- DEMO_RIGHT:
  - RightMove = 1, LeftMove = 0.
  - On startOfFrame with shipX >= DEMO_RIGHT_LIMIT (signed compare), go to DEMO_LEFT.
- DEMO_LEFT:
  - LeftMove = 1, RightMove = 0.
  - On startOfFrame with shipX <= DEMO_LEFT_LIMIT, go to DEMO_RIGHT.
- Demo fire:
  - The fire counter increments on each startOfFrame in a DEMO state.
  - When it reaches DEMO_FIRE_PERIOD-1, fireReq pulses for one clk and the counter clears.
- Exit from demo:
  - Any clk with anyKey = 1 in a DEMO state goes to MANUAL and clears the idle counter. This has priority over startOfFrame transitions and the demo fire pulse in that cycle.
  - The exiting key press is consumed: no fireReq is generated for a keyFire edge that causes the exit.
- demoActive = 1 exactly when the next state is DEMO_RIGHT or DEMO_LEFT.

## Timing
- Reset values: state MANUAL; both counters 0; RightMove, LeftMove, fireReq, demoActive all 0; keyFire delay register 0.
- Latency:
  - All outputs are registered and reflect inputs sampled on the previous clk edge (1-cycle latency).
  - In MANUAL, a key change at clk edge n appears on the outputs after edge n+1.
- Frame alignment:
  - Outputs updated by a startOfFrame decision change one clk after that pulse.
  - The move datapath samples on the same startOfFrame, so it uses the new direction from the following frame. This one-frame lag is required behaviour.
- Demo entry: with anyKey = 0 from reset, IDLE_FRAMES increments occur on the first IDLE_FRAMES startOfFrame pulses. DEMO_RIGHT is entered on pulse IDLE_FRAMES+1.
- Reset asserted mid-operation (any state) returns everything to the reset values immediately, asynchronously.
- fireReq is never high for two consecutive clks.

## Test plan
- Reset and manual keys: assert resetN = 0 -> all outputs 0. Release reset, hold keyRight -> RightMove = 1 one clk later. Hold both keys -> RightMove = LeftMove = 0.
- Manual fire: hold keyFire for 10 clks -> exactly one fireReq pulse, 1 clk after the rising edge.
- Idle timeout: no keys, 301 startOfFrame pulses -> demoActive = 1 and RightMove = 1 after the 301st pulse, not earlier. A key press at pulse 150 restarts the count.
- Demo reversal: in DEMO_RIGHT, drive shipX = 569 then 570 at startOfFrame -> LeftMove = 1 only after the 570 frame. In DEMO_LEFT, shipX = 5 -> RightMove = 1.
- Demo fire and exit:
  - In demo, fireReq pulses once every 45 frames.
  - keyFire pressed in the same clk as startOfFrame -> MANUAL, demoActive = 0, no fireReq.
- Reset mid-demo: drop resetN while in DEMO_LEFT -> state MANUAL and outputs 0 immediately. The idle count restarts from 0.
